// File: rtl/top_ej4.sv
// top_ej4: fixed-coefficient signed IIR filter, one sample per clock.
//   y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + y[n-1]/2 + y[n-2]/4
// The divisions are arithmetic right shifts, so they round toward -infinity.
// All arithmetic wraps modulo 2^NB_DATA; there is no saturation.
// The output is combinational from i_x and the delay line, with no clock latency.
`timescale 1ns/1ps
module top_ej4 #(
  parameter int NB_DATA = 8
) (
  input  logic                      clock,
  input  logic                      i_rst,
  input  logic signed [NB_DATA-1:0] i_x,
  output logic signed [NB_DATA-1:0] o_y
);

  // Delay line: past inputs and past outputs
  logic signed [NB_DATA-1:0] r_xm1;
  logic signed [NB_DATA-1:0] r_xm2;
  logic signed [NB_DATA-1:0] r_xm3;
  logic signed [NB_DATA-1:0] r_ym1;
  logic signed [NB_DATA-1:0] r_ym2;

  // Filter sum, truncated to NB_DATA bits (two's complement wrap)
  logic signed [NB_DATA-1:0] y_sum;

  // Filter equation; every operand is NB_DATA wide, so the sum wraps naturally
  always_comb begin
    y_sum = i_x - r_xm1 + r_xm2 + r_xm3 + (r_ym1 >>> 1) + (r_ym2 >>> 2);
  end

  // Output is forced to zero while reset is held, otherwise it follows the sum
  always_comb begin
    o_y = {NB_DATA{1'b0}};
    if (i_rst) begin
      o_y = {NB_DATA{1'b0}};
    end else begin
      o_y = y_sum;
    end
  end

  // Shift the delay line every clock; reset clears all history
  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_xm1 <= {NB_DATA{1'b0}};
      r_xm2 <= {NB_DATA{1'b0}};
      r_xm3 <= {NB_DATA{1'b0}};
      r_ym1 <= {NB_DATA{1'b0}};
      r_ym2 <= {NB_DATA{1'b0}};
    end else begin
      r_xm1 <= i_x;
      r_xm2 <= r_xm1;
      r_xm3 <= r_xm2;
      r_ym1 <= y_sum;
      r_ym2 <= r_ym1;
    end
  end

endmodule

// File: tb/tb_top_ej4.sv
// tb_top_ej4: scoreboard bench for the top_ej4 IIR filter.
// The stimulus process applies one sample per cycle and pushes the expected
// output, taken from a sequence-history reference model, into a queue.
// The monitor pops one entry on each falling edge and compares it with o_y.
`timescale 1ns/1ps
module tb_top_ej4;

  logic              clock;
  logic              i_rst;
  logic signed [7:0] i_x;
  logic signed [7:0] o_y;

  top_ej4 #(.NB_DATA(8)) dut (
    .clock (clock),
    .i_rst (i_rst),
    .i_x   (i_x),
    .o_y   (o_y)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected value and comparison name
  int    exp_q[$];
  string name_q[$];

  // Reference model: histories of consumed inputs and produced outputs, newest first
  int xh[$];
  int yh[$];
  bit cur_rst;
  int cur_x;
  int cur_y;

  function automatic int wrap8(input int v);
    int r;
    r = v & 255;
    if (r >= 128) r = r - 256;
    return r;
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_y(input int x);
    return wrap8(x - xh[0] + xh[1] + xh[2] + floor_div(yh[0], 2) + floor_div(yh[1], 4));
  endfunction

  // One cycle: commit the model at the edge, apply new input, queue the expectation
  task automatic step(input bit rst, input int x, input bit has_dir, input int dir, input string name);
    @(posedge clock);
    if (cur_rst) begin
      xh = '{0, 0, 0};
      yh = '{0, 0};
    end else begin
      xh.push_front(cur_x);
      void'(xh.pop_back());
      yh.push_front(cur_y);
      void'(yh.pop_back());
    end
    #1;
    cur_rst = rst;
    cur_x   = wrap8(x);
    cur_y   = rst ? 0 : model_y(cur_x);
    i_rst   = rst;
    i_x     = 8'(cur_x);
    exp_q.push_back(has_dir ? dir : cur_y);
    name_q.push_back(name);
  endtask

  // Monitor: compare the presented output against the oldest expectation
  always @(negedge clock) begin
    int    e;
    int    act;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = int'(o_y);
      checks++;
      if (act != e) begin
        errors++;
        $display("FAIL %s: o_y=%0d expected %0d (t=%0t)", nm, act, e, $time);
      end
    end
  end

  initial begin
    xh = '{0, 0, 0};
    yh = '{0, 0};
    cur_rst = 1'b1;
    cur_x   = 0;
    cur_y   = 0;
    i_rst   = 1'b1;
    i_x     = 8'sd0;

    // Reset state: output forced to zero even with nonzero input
    step(1'b1, 0,  1'b1, 0, "reset_zero");
    step(1'b1, 77, 1'b1, 0, "reset_forced");

    // Impulse response
    step(1'b0, 1, 1'b1, 1, "impulse_0");
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 0, "impulse_tail");

    // Ramp with truncating shifts
    step(1'b1, 0, 1'b1, 0, "ramp_reset");
    step(1'b0, 1, 1'b1, 1,  "ramp_0");
    step(1'b0, 2, 1'b1, 1,  "ramp_1");
    step(1'b0, 3, 1'b1, 2,  "ramp_2");
    step(1'b0, 4, 1'b1, 5,  "ramp_3");
    step(1'b0, 1, 1'b1, 4,  "ramp_4");
    step(1'b0, 2, 1'b1, 11, "ramp_5");

    // Reset mid-run: output zero, then history cleared
    step(1'b1, 55,  1'b1, 0, "midrst_0");
    step(1'b1, -20, 1'b1, 0, "midrst_1");
    step(1'b0, 1,   1'b1, 1, "midrst_release");
    step(1'b0, 1,   1'b0, 0, "midrst_after");

    // Negative input held: exercises rounding toward -infinity
    step(1'b1, -3, 1'b1, 0, "neg_reset");
    step(1'b0, -3, 1'b1, -3, "neg_0");
    for (int i = 0; i < 8; i++) step(1'b0, -3, 1'b0, 0, "neg_hold");

    // Wraparound
    step(1'b1, 0,   1'b1, 0,   "wrap_reset");
    step(1'b0, 127, 1'b1, 127, "wrap_0");
    step(1'b0, 127, 1'b1, 63,  "wrap_1");
    step(1'b0, 127, 1'b1, -67, "wrap_2");
    step(1'b0, -128, 1'b0, 0,  "wrap_3");
    step(1'b0, -128, 1'b0, 0,  "wrap_4");

    // Randomized samples with occasional reset
    for (int i = 0; i < 400; i++) begin
      int rx;
      bit rr;
      rx = $urandom_range(255, 0) - 128;
      rr = ($urandom_range(24, 0) == 0);
      step(rr, rx, 1'b0, 0, "random");
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
